// File: rtl/stopwatch_render_pkg.sv
// Shared types for the stopwatch renderer: segment bit order, 7-segment table,
// cell kinds and converter states.
package stopwatch_render_pkg;

    typedef logic [6:0] seg_t;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    // Bit order {a,b,c,d,e,f,g}
    localparam seg_t SEG_TABLE [10] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };

    typedef enum logic [1:0] {CELL_DIGIT, CELL_SEP, CELL_GAP, CELL_NONE} cell_kind_t;

    typedef enum logic [1:0] {ST_IDLE, ST_CONVERT, ST_COMMIT} conv_state_t;

    function automatic seg_t seg_encode(input logic [3:0] digit);
        seg_t s;
        s = '0;
        if (digit < 4'd10) s = SEG_TABLE[digit];
        return s;
    endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Combinational 7-segment glyph: is local pixel (x,y) of a digit cell lit for this digit?
module seg7_glyph
    import stopwatch_render_pkg::*;
#(
    parameter int SEG_W   = 4,
    parameter int DIGIT_W = 40,
    parameter int DIGIT_H = 80
) (
    input  logic [3:0]  digit,
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic        lit
);

    int   xi;
    int   yi;
    logic upper;
    seg_t on;

    always_comb begin
        xi    = int'(x);
        yi    = int'(y);
        upper = (yi < DIGIT_H / 2);
        on    = seg_encode(digit);
        lit   = (on[SEG_A] && (yi < SEG_W))
             || (on[SEG_D] && (yi >= DIGIT_H - SEG_W))
             || (on[SEG_G] && (yi >= DIGIT_H / 2 - SEG_W / 2)
                           && (yi <  DIGIT_H / 2 + SEG_W - SEG_W / 2))
             || (on[SEG_F] && (xi < SEG_W) && upper)
             || (on[SEG_E] && (xi < SEG_W) && !upper)
             || (on[SEG_B] && (xi >= DIGIT_W - SEG_W) && upper)
             || (on[SEG_C] && (xi >= DIGIT_W - SEG_W) && !upper);
    end

endmodule

// File: rtl/stopwatch_renderer.sv
// Stopwatch time overlay: per-frame snapshot with sequential BCD conversion and a
// 2-stage pixel pipeline that draws 7-segment digits and blinking separators.
module stopwatch_renderer
    import stopwatch_render_pkg::*;
#(
    parameter int         X0           = 125,
    parameter int         Y0           = 200,
    parameter int         DIGIT_W      = 40,
    parameter int         DIGIT_H      = 80,
    parameter int         SEG_W        = 4,
    parameter int         GAP          = 4,
    parameter int         COLON_W      = 10,
    parameter int         MS_DIGITS    = 3,
    parameter logic [2:0] COLOR        = 3'b010,
    parameter int         BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        blink_en,
    input  logic        frame_start,
    input  logic [3:0]  hours,
    input  logic [5:0]  minutes,
    input  logic [5:0]  seconds,
    input  logic [9:0]  milliseconds,
    input  logic        pixel_valid,
    input  logic [15:0] row,
    input  logic [15:0] column,
    output logic        r,
    output logic        g,
    output logic        b,
    output logic        busy
);

    localparam int NCELLS    = 8 + MS_DIGITS;
    localparam int BOX_W     = (5 + MS_DIGITS) * DIGIT_W + 3 * COLON_W + (7 + MS_DIGITS) * GAP;
    localparam int BLINK_MOD = 2 * BLINK_FRAMES;
    localparam int BW        = (BLINK_MOD > 1) ? $clog2(BLINK_MOD) : 1;

    conv_state_t state, state_next;
    logic [3:0]  hr_sh, min_tens, sec_tens, ms_hund, ms_tens;
    logic [3:0]  min_tens_n, sec_tens_n, ms_hund_n, ms_tens_n;
    logic [5:0]  min_rem, sec_rem, min_rem_n, sec_rem_n;
    logic [9:0]  ms_rem, ms_rem_n;
    logic [3:0]  disp [8];
    logic [BW-1:0] blink_cnt;

    // One subtraction step per field per cycle; leave CONVERT on the step that finishes.
    always_comb begin
        state_next = state;
        ms_rem_n   = ms_rem;
        ms_hund_n  = ms_hund;
        ms_tens_n  = ms_tens;
        min_rem_n  = min_rem;
        min_tens_n = min_tens;
        sec_rem_n  = sec_rem;
        sec_tens_n = sec_tens;
        case (state)
            ST_IDLE: if (frame_start) state_next = ST_CONVERT;
            ST_CONVERT: begin
                if (ms_rem >= 10'd100) begin
                    ms_rem_n  = ms_rem - 10'd100;
                    ms_hund_n = ms_hund + 4'd1;
                end else if (ms_rem >= 10'd10) begin
                    ms_rem_n  = ms_rem - 10'd10;
                    ms_tens_n = ms_tens + 4'd1;
                end
                if (min_rem >= 6'd10) begin
                    min_rem_n  = min_rem - 6'd10;
                    min_tens_n = min_tens + 4'd1;
                end
                if (sec_rem >= 6'd10) begin
                    sec_rem_n  = sec_rem - 6'd10;
                    sec_tens_n = sec_tens + 4'd1;
                end
                if ((ms_rem_n < 10'd10) && (min_rem_n < 6'd10) && (sec_rem_n < 6'd10))
                    state_next = ST_COMMIT;
            end
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            hr_sh    <= '0;
            min_rem  <= '0;
            sec_rem  <= '0;
            ms_rem   <= '0;
            min_tens <= '0;
            sec_tens <= '0;
            ms_hund  <= '0;
            ms_tens  <= '0;
            for (int i = 0; i < 8; i++) disp[i] <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: if (frame_start) begin
                    hr_sh    <= (hours > 4'd9) ? 4'd9 : hours;
                    min_rem  <= (minutes > 6'd59) ? 6'd59 : minutes;
                    sec_rem  <= (seconds > 6'd59) ? 6'd59 : seconds;
                    ms_rem   <= (milliseconds > 10'd999) ? 10'd999 : milliseconds;
                    min_tens <= '0;
                    sec_tens <= '0;
                    ms_hund  <= '0;
                    ms_tens  <= '0;
                end
                ST_CONVERT: begin
                    min_rem  <= min_rem_n;
                    sec_rem  <= sec_rem_n;
                    ms_rem   <= ms_rem_n;
                    min_tens <= min_tens_n;
                    sec_tens <= sec_tens_n;
                    ms_hund  <= ms_hund_n;
                    ms_tens  <= ms_tens_n;
                end
                ST_COMMIT: begin
                    disp[0] <= hr_sh;
                    disp[1] <= min_tens;
                    disp[2] <= min_rem[3:0];
                    disp[3] <= sec_tens;
                    disp[4] <= sec_rem[3:0];
                    disp[5] <= ms_hund;
                    disp[6] <= ms_tens;
                    disp[7] <= ms_rem[3:0];
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n)
            blink_cnt <= '0;
        else if (frame_start)
            blink_cnt <= (blink_cnt == BW'(BLINK_MOD - 1)) ? '0 : blink_cnt + 1'b1;
    end

    cell_kind_t  kind_c, s1_kind;
    logic [2:0]  idx_c, s1_idx;
    logic [15:0] x_c, y_c, s1_x, s1_y;
    logic        s1_act;

    // Stage 1: locate the cell under the pixel; digit cells are numbered left to right.
    always_comb begin
        int col_i, row_i, pos, w, dig;
        kind_c = CELL_NONE;
        idx_c  = '0;
        x_c    = '0;
        y_c    = '0;
        col_i  = int'(column);
        row_i  = int'(row);
        pos    = X0;
        dig    = 0;
        w      = 0;
        if ((row_i >= Y0) && (row_i < Y0 + DIGIT_H) && (col_i >= X0) && (col_i < X0 + BOX_W)) begin
            kind_c = CELL_GAP;
            y_c    = 16'(row_i - Y0);
            for (int i = 0; i < NCELLS; i++) begin
                if (i == 1 || i == 4 || i == 7) begin
                    w = COLON_W;
                    if (col_i >= pos && col_i < pos + w) begin
                        kind_c = CELL_SEP;
                        x_c    = 16'(col_i - pos);
                    end
                end else begin
                    w = DIGIT_W;
                    if (col_i >= pos && col_i < pos + w) begin
                        kind_c = CELL_DIGIT;
                        idx_c  = 3'(dig);
                        x_c    = 16'(col_i - pos);
                    end
                    dig = dig + 1;
                end
                pos = pos + w + GAP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_kind <= CELL_NONE;
            s1_idx  <= '0;
            s1_x    <= '0;
            s1_y    <= '0;
            s1_act  <= 1'b0;
        end else begin
            s1_kind <= kind_c;
            s1_idx  <= idx_c;
            s1_x    <= x_c;
            s1_y    <= y_c;
            s1_act  <= enable && pixel_valid;
        end
    end

    logic [3:0] glyph_digit;
    logic       glyph_lit, dot_lit, sep_on, pix_lit;
    int         s1_yi;

    assign glyph_digit = disp[s1_idx];

    seg7_glyph #(
        .SEG_W   (SEG_W),
        .DIGIT_W (DIGIT_W),
        .DIGIT_H (DIGIT_H)
    ) u_glyph (
        .digit (glyph_digit),
        .x     (s1_x),
        .y     (s1_y),
        .lit   (glyph_lit)
    );

    // Stage 2: glyph/dot decode, then register the colour.
    always_comb begin
        s1_yi   = int'(s1_y);
        dot_lit = ((s1_yi >= DIGIT_H / 4) && (s1_yi < DIGIT_H / 4 + COLON_W))
               || ((s1_yi >= 3 * DIGIT_H / 4 - COLON_W) && (s1_yi < 3 * DIGIT_H / 4));
        sep_on  = !blink_en || (blink_cnt < BW'(BLINK_FRAMES));
        pix_lit = 1'b0;
        if (s1_act) begin
            case (s1_kind)
                CELL_DIGIT: pix_lit = glyph_lit;
                CELL_SEP:   pix_lit = dot_lit && sep_on;
                default:    pix_lit = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            {r, g, b} <= 3'b000;
        else
            {r, g, b} <= pix_lit ? COLOR : 3'b000;
    end

endmodule

// File: tb/tb_stopwatch_renderer.sv
// Directed self-checking bench for stopwatch_renderer: reset, conversion, clamping,
// blinking, pipeline latency and a single-ms-digit variant.
module tb_stopwatch_renderer;

    localparam int X0     = 125;
    localparam int Y0     = 200;
    localparam int BOX_W1 = (5 + 1) * 40 + 3 * 10 + (7 + 1) * 4;
    localparam int DOT_X  = X0 + 44 + 5;
    localparam int DOT_Y  = Y0 + 22;

    logic        clk = 1'b0;
    logic        rst_n, enable, blink_en, frame_start, pixel_valid;
    logic [3:0]  hours;
    logic [5:0]  minutes, seconds;
    logic [9:0]  milliseconds;
    logic [15:0] row, column;
    logic        r1, g1, b1, busy1, r2, g2, b2, busy2;

    int compared   = 0;
    int mismatched = 0;

    int         cell_off [8] = '{0, 58, 102, 160, 204, 262, 306, 350};
    int         pt_x [7]     = '{20, 39, 39, 20, 0, 0, 20};
    int         pt_y [7]     = '{1, 20, 60, 79, 60, 20, 40};
    logic [6:0] seg_ref [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    always #5 clk = ~clk;

    stopwatch_renderer #(.BLINK_FRAMES(2)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .blink_en(blink_en),
        .frame_start(frame_start), .hours(hours), .minutes(minutes), .seconds(seconds),
        .milliseconds(milliseconds), .pixel_valid(pixel_valid), .row(row), .column(column),
        .r(r1), .g(g1), .b(b1), .busy(busy1)
    );

    stopwatch_renderer #(.MS_DIGITS(1)) dut_ms1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .blink_en(blink_en),
        .frame_start(frame_start), .hours(hours), .minutes(minutes), .seconds(seconds),
        .milliseconds(milliseconds), .pixel_valid(pixel_valid), .row(row), .column(column),
        .r(r2), .g(g2), .b(b2), .busy(busy2)
    );

    task automatic checkOutput(input string tag, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int h, input int m, input int s, input int ms);
        @(negedge clk);
        hours        = 4'(h);
        minutes      = 6'(m);
        seconds      = 6'(s);
        milliseconds = 10'(ms);
        frame_start  = 1'b1;
        @(negedge clk);
        frame_start  = 1'b0;
    endtask

    task automatic waitIdle(input string tag, output int cycles);
        cycles = 0;
        while (busy1 && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
        checkOutput({tag, "_idle"}, busy1, 0);
    endtask

    task automatic probe(input int x, input int y, output logic [2:0] p1, output logic [2:0] p2);
        @(negedge clk);
        column      = 16'(x);
        row         = 16'(y);
        pixel_valid = 1'b1;
        enable      = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        p1 = {r1, g1, b1};
        p2 = {r2, g2, b2};
    endtask

    task automatic readGlyph(input int cx, input bit use_ms1, output logic [6:0] seg);
        logic [2:0] p1, p2;
        for (int i = 0; i < 7; i++) begin
            probe(X0 + cx + pt_x[i], Y0 + pt_y[i], p1, p2);
            seg[6-i] = use_ms1 ? (p2 != 3'b000) : (p1 != 3'b000);
        end
    endtask

    task automatic checkDigits(input string tag, input logic [31:0] expected);
        logic [6:0] seg;
        logic [3:0] d;
        for (int i = 0; i < 8; i++) begin
            d = expected[31-4*i -: 4];
            readGlyph(cell_off[i], 1'b0, seg);
            checkOutput($sformatf("%s_d%0d", tag, i), seg, seg_ref[d]);
        end
    endtask

    initial begin
        logic [2:0] p1, p2;
        logic [6:0] seg;
        logic       pv_hist [12];
        int         n;

        rst_n        = 1'b0;
        enable       = 1'b1;
        blink_en     = 1'b0;
        frame_start  = 1'b0;
        pixel_valid  = 1'b1;
        hours        = '0;
        minutes      = '0;
        seconds      = '0;
        milliseconds = '0;
        column       = 16'(X0 + 1);
        row          = 16'(Y0 + 1);

        $display("[TB] reset");
        repeat (3) @(negedge clk);
        checkOutput("rst_rgb", {r1, g1, b1}, 0);
        checkOutput("rst_busy", busy1, 0);
        rst_n = 1'b1;
        probe(X0 + 1, Y0 + 1, p1, p2);
        checkOutput("rst_seg_a", p1, 3'b010);
        probe(X0 + 20, Y0 + 40, p1, p2);
        checkOutput("rst_h_centre", p1, 0);

        $display("[TB] conversion 7:45:38.999");
        applyStimulus(7, 45, 38, 999);
        waitIdle("conv", n);
        checkOutput("conv_busy_cycles", n, 19);
        checkDigits("conv", 32'h74538999);
        probe(X0 + 204 + 20, Y0 + 40, p1, p2);
        checkOutput("conv_s0_g", p1, 3'b010);

        $display("[TB] clamping and dropped pulse");
        applyStimulus(12, 63, 38, 1023);
        repeat (2) @(negedge clk);
        applyStimulus(1, 10, 0, 0);
        waitIdle("clamp", n);
        checkDigits("clamp", 32'h95938999);
        repeat (10) @(negedge clk);
        checkOutput("hold_busy", busy1, 0);
        readGlyph(cell_off[0], 1'b0, seg);
        checkOutput("hold_h", seg, seg_ref[9]);
        applyStimulus(1, 10, 0, 0);
        waitIdle("next", n);
        checkDigits("next", 32'h11000000);

        $display("[TB] ms 987, one-digit variant");
        applyStimulus(0, 0, 0, 987);
        waitIdle("ms987", n);
        checkDigits("ms987", 32'h00000987);
        readGlyph(262, 1'b1, seg);
        checkOutput("ms1_digit", seg, seg_ref[9]);
        probe(X0 + BOX_W1 - 1, Y0 + 1, p1, p2);
        checkOutput("ms1_last_col", p2, 3'b010);
        probe(X0 + BOX_W1, Y0 + 1, p1, p2);
        checkOutput("ms1_box_edge", p2, 0);
        probe(X0 + 306 + 20, Y0 + 1, p1, p2);
        checkOutput("ms1_no_tens", p2, 0);

        $display("[TB] pipeline latency");
        @(negedge clk);
        column = 16'(DOT_X);
        row    = 16'(DOT_Y);
        enable = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k >= 2)
                checkOutput($sformatf("pipe_%0d", k), {r1, g1, b1}, pv_hist[k-2] ? 3'b010 : 3'b000);
            pv_hist[k]  = (k % 2) == 1;
            pixel_valid = pv_hist[k];
            @(negedge clk);
        end
        pixel_valid = 1'b1;
        repeat (3) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        checkOutput("en_lat1", {r1, g1, b1}, 3'b010);
        @(negedge clk);
        checkOutput("en_off", {r1, g1, b1}, 0);
        enable = 1'b1;

        $display("[TB] reset during conversion");
        applyStimulus(7, 45, 38, 999);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rstmid_busy", busy1, 0);
        rst_n = 1'b1;
        checkDigits("rstmid", 32'h00000000);

        $display("[TB] blink");
        blink_en = 1'b1;
        for (int f = 0; f < 8; f++) begin
            probe(DOT_X, DOT_Y, p1, p2);
            checkOutput($sformatf("blink_f%0d", f), p1, ((f % 4) < 2) ? 3'b010 : 3'b000);
            applyStimulus(0, 0, 0, 0);
        end
        blink_en = 1'b0;
        probe(DOT_X, DOT_Y, p1, p2);
        checkOutput("blink_off", p1, 3'b010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
